// File: rtl/md_sched.sv
// Multiply/divide sequencer owning HI/LO: fixed-latency counter, commit at end, ID stall request.
// Optional MD_SCHED_CANCEL_EN adds a cancel input that aborts a running op without commit.
module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
`ifdef MD_SCHED_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_id,
    input  logic        rd_sel,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);
    localparam int CW = $clog2(DIV_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    op_q;
    logic [31:0]   a_q, b_q;
    logic [31:0]   hi_q, lo_q, hi_nxt, lo_nxt;
    logic          load;
    logic          cancel_i;
    logic          is_long;

`ifdef MD_SCHED_CANCEL_EN
    assign cancel_i = cancel;
`else
    assign cancel_i = 1'b0;
`endif

    assign is_long = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                     (md_op == OP_DIV)  || (md_op == OP_DIVU);

    // Result datapath works from the latched operands only.
    logic [63:0]        smul, umul;
    logic [31:0]        dvs;
    logic signed [31:0] sq, sr;
    logic [31:0]        res_hi, res_lo;

    always_comb begin
        smul   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        umul   = {32'd0, a_q} * {32'd0, b_q};
        // Substitute divisor keeps the dividers X-free; the zero case never commits.
        dvs    = (b_q == 32'd0) ? 32'd1 : b_q;
        sq     = $signed(a_q) / $signed(dvs);
        sr     = $signed(a_q) % $signed(dvs);
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            OP_MULT:  {res_hi, res_lo} = smul;
            OP_MULTU: {res_hi, res_lo} = umul;
            OP_DIV:   if (b_q != 32'd0) begin
                          res_lo = sq;
                          res_hi = sr;
                      end
            OP_DIVU:  if (b_q != 32'd0) begin
                          res_lo = a_q / dvs;
                          res_hi = a_q % dvs;
                      end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_nxt    = hi_q;
        lo_nxt    = lo_q;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !cancel_i) begin
                    if (is_long) begin
                        load      = 1'b1;
                        cnt_nxt   = (md_op == OP_DIV || md_op == OP_DIVU) ?
                                    CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state_nxt = RUN;
                    end else if (md_op == OP_MTHI) begin
                        hi_nxt = rs_val;
                    end else if (md_op == OP_MTLO) begin
                        lo_nxt = rs_val;
                    end
                end
            end
            RUN: begin
                if (cancel_i) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    hi_nxt    = res_hi;
                    lo_nxt    = res_lo;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            if (load) begin
                op_q <= md_op;
                a_q  <= rs_val;
                b_q  <= rt_val;
            end
        end
    end

    assign busy      = (state == RUN);
    // Gated by reset so a start presented during reset cannot raise a stall.
    assign stall_req = reset_n & md_use_id & (busy | (start & is_long));
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign md_out    = rd_sel ? lo_q : hi_q;
endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: vector table through a result scoreboard plus stall/reset/cancel sequences.
module tb_md_sched;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        md_use_id = 1'b0;
    logic        rd_sel = 1'b0;
`ifdef MD_SCHED_CANCEL_EN
    logic        cancel = 1'b0;
`endif
    logic        busy, stall_req;
    logic [31:0] hi, lo, md_out;

    int n_chk = 0;
    int n_fail = 0;

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op),
`ifdef MD_SCHED_CANCEL_EN
        .cancel(cancel),
`endif
        .rs_val(rs_val), .rt_val(rt_val), .md_use_id(md_use_id), .rd_sel(rd_sel),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .md_out(md_out)
    );

    always #5 clk = ~clk;

    // Issuing a start while busy is a bench bug.
    always @(posedge clk) begin
        if (reset_n && start && busy) begin
            n_fail++;
            $display("FAIL start_while_busy: start=1 busy=1 required busy=0");
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one op for a single cycle, then count busy cycles until idle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        tick();
        start = 1'b0; md_op = 3'd0;
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            tick();
        end
        if (busy) begin
            n_chk++; n_fail++;
            $display("FAIL busy_timeout: busy still 1 after %0d cycles", cyc);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs, rt, ehi, elo;
        int          ecyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[15];

    initial begin
        int   cyc;
        exp_t e;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2]  = '{3'd4, 32'd100,       32'd7,        32'd2,         32'd14,        10};
        vecs[3]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[4]  = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 10};
        vecs[5]  = '{3'd5, 32'h11,        32'd0,        32'h11,        32'hFFFF_FFFD, 0};
        vecs[6]  = '{3'd6, 32'h22,        32'd0,        32'h11,        32'h22,        0};
        vecs[7]  = '{3'd3, 32'd5,         32'd0,        32'h11,        32'h22,        10};
        vecs[8]  = '{3'd4, 32'd5,         32'd0,        32'h11,        32'h22,        10};
        vecs[9]  = '{3'd5, 32'hDEAD_BEEF, 32'd0,        32'hDEAD_BEEF, 32'h22,        0};
        vecs[10] = '{3'd0, 32'h1234_5678, 32'd3,        32'hDEAD_BEEF, 32'h22,        0};
        vecs[11] = '{3'd7, 32'h1234_5678, 32'd3,        32'hDEAD_BEEF, 32'h22,        0};
        vecs[12] = '{3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
        vecs[13] = '{3'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
        vecs[14] = '{3'd3, 32'h8000_0000, 32'd3,        32'hFFFF_FFFE, 32'hD555_5556, 10};

        // Reset state, including a long op presented while reset is held.
        start = 1'b1; md_op = 3'd1; md_use_id = 1'b1;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        start = 1'b0; md_op = 3'd0; md_use_id = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        foreach (vecs[i]) begin
            e.hi = vecs[i].ehi; e.lo = vecs[i].elo; e.cyc = vecs[i].ecyc;
            sb.push_back(e);
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, cyc);
            e = sb.pop_front();
            check($sformatf("v%0d_cycles", i), cyc, e.cyc);
            check($sformatf("v%0d_hi", i), hi, e.hi);
            check($sformatf("v%0d_lo", i), lo, e.lo);
            rd_sel = 1'b0; #1;
            check($sformatf("v%0d_mdout_hi", i), md_out, e.hi);
            rd_sel = 1'b1; #1;
            check($sformatf("v%0d_mdout_lo", i), md_out, e.lo);
        end

        // mult followed by mflo in ID: stall through the busy window only.
        rd_sel = 1'b1; md_use_id = 1'b0;
        start = 1'b1; md_op = 3'd1; rs_val = 32'd6; rt_val = 32'hFFFF_FFFB;
        #1;
        check("stall_no_use", {31'd0, stall_req}, 32'd0);
        md_use_id = 1'b1; #1;
        check("stall_start", {31'd0, stall_req}, 32'd1);
        tick();
        start = 1'b0; md_op = 3'd0;
        cyc = 0;
        while (busy && cyc < 40) begin
            check($sformatf("stall_busy%0d", cyc), {31'd0, stall_req}, 32'd1);
            check($sformatf("stall_hold_lo%0d", cyc), lo, 32'hD555_5556);
            cyc++;
            tick();
        end
        check("stall_cycles", cyc, 5);
        check("stall_after", {31'd0, stall_req}, 32'd0);
        check("stall_mflo", md_out, 32'hFFFF_FFE2);
        md_use_id = 1'b0;

`ifdef MD_SCHED_CANCEL_EN
        // Cancel mid-div, on the commit cycle, and alongside an IDLE mthi/start.
        start = 1'b1; md_op = 3'd4; rs_val = 32'd100; rt_val = 32'd7;
        tick(); start = 1'b0; md_op = 3'd0;
        tick(); tick();
        cancel = 1'b1; tick(); cancel = 1'b0;
        check("cancel_busy", {31'd0, busy}, 32'd0);
        check("cancel_hi", hi, 32'hFFFF_FFFF);
        check("cancel_lo", lo, 32'hFFFF_FFE2);
        start = 1'b1; md_op = 3'd1; rs_val = 32'd2; rt_val = 32'd3;
        tick(); start = 1'b0; md_op = 3'd0;
        repeat (4) tick();
        check("cancel_commit_busy_before", {31'd0, busy}, 32'd1);
        cancel = 1'b1; tick(); cancel = 1'b0;
        check("cancel_commit_busy", {31'd0, busy}, 32'd0);
        check("cancel_commit_lo", lo, 32'hFFFF_FFE2);
        cancel = 1'b1; start = 1'b1; md_op = 3'd5; rs_val = 32'h123;
        tick();
        md_op = 3'd1;
        tick();
        cancel = 1'b0; start = 1'b0; md_op = 3'd0;
        check("cancel_idle_hi", hi, 32'hFFFF_FFFF);
        check("cancel_idle_busy", {31'd0, busy}, 32'd0);
`endif

        // Asynchronous reset during cycle 3 of a div.
        start = 1'b1; md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd7;
        tick(); start = 1'b0; md_op = 3'd0;
        tick(); tick();
        check("mid_div_busy", {31'd0, busy}, 32'd1);
        #2;
        reset_n = 1'b0; md_use_id = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_stall", {31'd0, stall_req}, 32'd0);
        md_use_id = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) tick();
        check("arst_after_busy", {31'd0, busy}, 32'd0);
        check("arst_after_lo", lo, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
